// File: rtl/vd_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | vd_pkg : code constants, symbol and state types shared by encoder/decoder.   |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
package vd_pkg;

  localparam int              VD_K  = 3;
  localparam logic [VD_K-1:0] VD_G0 = 3'b111;
  localparam logic [VD_K-1:0] VD_G1 = 3'b101;

  typedef logic [1:0] vd_sym_t;

  typedef enum logic [1:0] {
    ENC_IDLE = 2'd0,
    ENC_SEND = 2'd1,
    ENC_TAIL = 2'd2,
    ENC_DONE = 2'd3
  } enc_state_t;

  // Window is {u, s1, s0}; a generator bit selects a tap into the XOR.
  function automatic logic parity_tap(input logic [VD_K-1:0] win,
                                      input logic [VD_K-1:0] gen);
    return ^(win & gen);
  endfunction

endpackage
`default_nettype wire

// File: rtl/convolutional_encoder_tx_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | convolutional_encoder_tx_if : frame request and symbol stream bundle.        |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
interface convolutional_encoder_tx_if
  import vd_pkg::*;
#(
  parameter int DATA_W = 8
) ();

  logic              i_start;
  logic [DATA_W-1:0] i_data;
  logic              i_ready;
  vd_sym_t           o_data;
  logic              o_valid;
  logic              o_busy;
  logic              o_done;

  modport master (
    output i_start, i_data, i_ready,
    input  o_data, o_valid, o_busy, o_done
  );

  modport slave (
    input  i_start, i_data, i_ready,
    output o_data, o_valid, o_busy, o_done
  );

endinterface
`default_nettype wire

// File: rtl/conv_enc_core.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | conv_enc_core : rate-1/2 K=3 trellis state and symbol generator.            |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module conv_enc_core
  import vd_pkg::*;
(
  input  logic    i_clk,
  input  logic    i_rst_n,
  input  logic    i_u,
  input  logic    i_step,
  input  logic    i_clear,
  output vd_sym_t o_sym
);

  logic            r_s1;
  logic            r_s0;
  logic [VD_K-1:0] w_win;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_s1 <= 1'b0;
      r_s0 <= 1'b0;
    end else if (i_clear) begin
      r_s1 <= 1'b0;
      r_s0 <= 1'b0;
    end else if (i_step) begin
      r_s1 <= i_u;
      r_s0 <= r_s1;
    end
  end

  assign w_win = {i_u, r_s1, r_s0};
  assign o_sym = {parity_tap(w_win, VD_G0), parity_tap(w_win, VD_G1)};

endmodule
`default_nettype wire

// File: rtl/convolutional_encoder_tx.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | convolutional_encoder_tx : serialise a word MSB-first into encoded symbols. |
// | TAIL_FLUSH_EN adds two zero tail bits to return the trellis to state 00.    |
// | Rev 1.0 - initial release                                                   |
// +-----------------------------------------------------------------------------+
module convolutional_encoder_tx
  import vd_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input logic                       i_clk,
  input logic                       i_rst_n,
  convolutional_encoder_tx_if.slave bus
);

  localparam int CW = $clog2(DATA_W);

  enc_state_t        r_state;
  enc_state_t        w_next;
  logic [DATA_W-1:0] r_shift;
  logic [CW-1:0]     r_cnt;
  logic              w_valid;
  logic              w_busy;
  logic              w_done;
  logic              w_u;
  logic              w_xfer;
  logic              w_last;
  logic              w_start;
  vd_sym_t           w_sym;

  assign w_xfer  = w_valid & bus.i_ready;
  assign w_last  = (r_cnt == '0);
  assign w_start = (r_state == ENC_IDLE) & bus.i_start;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ENC_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ENC_IDLE: if (bus.i_start) w_next = ENC_SEND;
      ENC_SEND: begin
        if (w_xfer && w_last) begin
`ifdef TAIL_FLUSH_EN
          w_next = ENC_TAIL;
`else
          w_next = ENC_DONE;
`endif
        end
      end
`ifdef TAIL_FLUSH_EN
      ENC_TAIL: if (w_xfer && w_last) w_next = ENC_DONE;
`endif
      ENC_DONE: w_next = ENC_IDLE;
      default:  w_next = ENC_IDLE;
    endcase
  end

  // Outputs decode from the state register only, so i_ready never reaches o_valid.
  always_comb begin
    w_valid = 1'b0;
    w_busy  = 1'b1;
    w_done  = 1'b0;
    w_u     = 1'b0;
    case (r_state)
      ENC_IDLE: w_busy = 1'b0;
      ENC_SEND: begin
        w_valid = 1'b1;
        w_u     = r_shift[DATA_W-1];
      end
`ifdef TAIL_FLUSH_EN
      ENC_TAIL: w_valid = 1'b1;
`endif
      ENC_DONE: w_done = 1'b1;
      default:  w_busy = 1'b1;
    endcase
  end

  // Counter doubles as the tail-bit counter once the payload is exhausted.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (w_start) begin
      r_shift <= bus.i_data;
      r_cnt   <= CW'(DATA_W - 1);
    end else if (w_xfer) begin
      r_shift <= {r_shift[DATA_W-2:0], 1'b0};
      r_cnt   <= w_last ? CW'(VD_K - 2) : (r_cnt - CW'(1));
    end
  end

  conv_enc_core u_core (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_u     (w_u),
    .i_step  (w_xfer),
    .i_clear (w_start),
    .o_sym   (w_sym)
  );

  assign bus.o_data  = w_valid ? w_sym : 2'b00;
  assign bus.o_valid = w_valid;
  assign bus.o_busy  = w_busy;
  assign bus.o_done  = w_done;

endmodule
`default_nettype wire
